// File: rtl/sdpb_line_buffer_pkg.sv
// sdpb_line_buffer_pkg: shared ISP constants (parameter bounds, address width, tap indexing)
package sdpb_line_buffer_pkg;

   localparam int LINES_MIN     = 1;
   localparam int LINES_MAX     = 8;
   localparam int MAX_WIDTH_MIN = 2;
   localparam int LINE_CNT_W    = 4;

   function automatic int addr_w(input int max_width);
      return (max_width > 1) ? $clog2(max_width) : 1;
   endfunction

   function automatic int tap_lo(input int k, input int data_w);
      return k * data_w;
   endfunction

endpackage

// File: rtl/sdpb_line_buffer_sdp_ram.sv
// sdp_ram: single-clock simple dual-port RAM with registered read (old data on same-address collision)
//   clk      : clock
//   wr_en    : write strobe, wr_addr/wr_data : write port
//   rd_en    : read strobe, rd_addr : read address
//   rd_data  : registered read data, held while rd_en is low
module sdp_ram
   import sdpb_line_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4096
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [addr_w(DEPTH)-1:0]  wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   input  logic [addr_w(DEPTH)-1:0]  rd_addr,
   output logic [WIDTH-1:0]          rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sdpb_line_buffer.sv
// sdpb_line_buffer: vertical line buffer delivering one column of LINES+1 taps per input pixel
//   clk, rst_n : clock, asynchronous active-low reset
//   img_width  : pixels per line, latched on in_valid & in_sof
//   in_valid, in_sof, in_data : pixel stream, in_sof marks column 0 of a frame
//   out_valid  : taps valid, exactly one cycle after in_valid
//   out_taps   : tap k = same column k lines above, tap 0 in the LSBs, masked above out_lines
//   out_col, out_eol, out_lines : column, last-column flag, count of valid upper taps
module sdpb_line_buffer
   import sdpb_line_buffer_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int LINES     = 2,
   parameter int MAX_WIDTH = 4096
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [addr_w(MAX_WIDTH):0]      img_width,
   input  logic                            in_valid,
   input  logic                            in_sof,
   input  logic [DATA_W-1:0]               in_data,
   output logic                            out_valid,
   output logic [(LINES+1)*DATA_W-1:0]     out_taps,
   output logic [addr_w(MAX_WIDTH)-1:0]    out_col,
   output logic                            out_eol,
   output logic [LINE_CNT_W-1:0]           out_lines
);

   localparam int ADDR_W = addr_w(MAX_WIDTH);
   localparam logic [LINE_CNT_W-1:0] LINES_C = LINE_CNT_W'(LINES);

   logic [ADDR_W:0]           width_q, cur_width;
   logic [ADDR_W-1:0]         col_q, cur_col;
   logic [LINE_CNT_W-1:0]     lines_q, cur_lines, lines_inc;
   logic                      last;
   logic [DATA_W-1:0]         pix_d1;
   logic [DATA_W-1:0]         rd_data [LINES];
   logic [DATA_W-1:0]         wr_src  [LINES];

   // An sof pixel restarts the frame: column 0, no valid upper lines, fresh width.
   always_comb begin
      cur_col   = in_sof ? '0 : col_q;
      cur_lines = in_sof ? '0 : lines_q;
      cur_width = in_sof ? img_width : width_q;
      last      = ({1'b0, cur_col} == cur_width - 1'b1);
      lines_inc = (cur_lines == LINES_C) ? cur_lines : cur_lines + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q   <= (ADDR_W+1)'(MAX_WIDTH);
         col_q     <= '0;
         lines_q   <= '0;
         out_valid <= 1'b0;
         out_col   <= '0;
         out_eol   <= 1'b0;
         out_lines <= '0;
         pix_d1    <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            width_q   <= cur_width;
            col_q     <= last ? '0 : cur_col + 1'b1;
            lines_q   <= last ? lines_inc : cur_lines;
            out_col   <= cur_col;
            out_eol   <= last;
            out_lines <= cur_lines;
            pix_d1    <= in_data;
         end
      end
   end

   // Each RAM is read at the incoming column and rewritten at the same column one
   // cycle later, so the read returns the previous line before it is overwritten.
   for (genvar k = 0; k < LINES; k++) begin : g_line
      if (k == 0) begin : g_head
         assign wr_src[k] = pix_d1;
      end else begin : g_chain
         assign wr_src[k] = rd_data[k-1];
      end
      sdp_ram #(
         .WIDTH (DATA_W),
         .DEPTH (MAX_WIDTH)
      ) u_ram (
         .clk     (clk),
         .wr_en   (out_valid),
         .wr_addr (out_col),
         .wr_data (wr_src[k]),
         .rd_en   (in_valid),
         .rd_addr (cur_col),
         .rd_data (rd_data[k])
      );
   end

   assign out_taps[tap_lo(0, DATA_W) +: DATA_W] = pix_d1;

   // Upper taps beyond the valid line count hide stale RAM contents.
   for (genvar k = 1; k <= LINES; k++) begin : g_tap
      assign out_taps[tap_lo(k, DATA_W) +: DATA_W] =
         (LINE_CNT_W'(k) <= out_lines) ? rd_data[k-1] : '0;
   end

endmodule

// File: tb/tb_sdpb_line_buffer.sv
// tb_sdpb_line_buffer: table vectors plus model-driven scoreboard for sdpb_line_buffer
module tb_sdpb_line_buffer;

   localparam int LINES = 2;

   typedef struct packed {
      logic [11:0] col;
      logic        eol;
      logic [3:0]  lines;
      logic [23:0] taps;
   } exp_t;

   typedef struct {
      logic        sof;
      logic [12:0] w;
      logic [7:0]  d;
      exp_t        e;
   } vec_t;

   logic        clk, rst_n, in_valid, in_sof, out_valid, out_eol;
   logic [12:0] img_width;
   logic [7:0]  in_data;
   logic [23:0] out_taps;
   logic [11:0] out_col;
   logic [3:0]  out_lines;

   int   n_chk, n_fail;
   bit   exp_v;
   exp_t q[$];
   vec_t tab[12];

   int   m_row, m_col, m_w;
   logic [7:0] fr [int];

   sdpb_line_buffer #(.DATA_W(8), .LINES(LINES), .MAX_WIDTH(4096)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .img_width (img_width),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_taps  (out_taps),
      .out_col   (out_col),
      .out_eol   (out_eol),
      .out_lines (out_lines)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic sof, input logic [7:0] d, input int col,
                               input logic eol, input int ln, input logic [23:0] taps);
      vec_t v;
      v.sof = sof; v.w = 13'd4; v.d = d;
      v.e.col = 12'(col); v.e.eol = eol; v.e.lines = 4'(ln); v.e.taps = taps;
      return v;
   endfunction

   function automatic exp_t model(input logic sof, input int w, input logic [7:0] d);
      exp_t e;
      int   ln;
      if (sof) begin m_row = 0; m_col = 0; m_w = w; fr.delete(); end
      fr[m_row*8192 + m_col] = d;
      ln = (m_row < LINES) ? m_row : LINES;
      e.col = 12'(m_col); e.eol = (m_col == m_w - 1); e.lines = 4'(ln); e.taps = '0;
      for (int k = 0; k <= ln; k++) e.taps[k*8 +: 8] = fr[(m_row - k)*8192 + m_col];
      if (e.eol) begin m_col = 0; m_row++; end else m_col++;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 0);
      chk({tag, "_col"},   64'(out_col),   0);
      chk({tag, "_eol"},   64'(out_eol),   0);
      chk({tag, "_lines"}, 64'(out_lines), 0);
      chk({tag, "_taps"},  64'(out_taps),  0);
   endtask

   task automatic step();
      exp_t e;
      exp_v = in_valid && rst_n;
      @(posedge clk); #1;
      chk("out_valid", 64'(out_valid), 64'(exp_v));
      if (out_valid) begin
         if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL extra_out: got out_valid=1 expected no pending pixel");
         end else begin
            e = q.pop_front();
            chk("out_col",   64'(out_col),   64'(e.col));
            chk("out_eol",   64'(out_eol),   64'(e.eol));
            chk("out_lines", 64'(out_lines), 64'(e.lines));
            chk("out_taps",  64'(out_taps),  64'(e.taps));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic sof, input logic [12:0] w, input logic [7:0] d,
                       input bit use_tab, input exp_t te);
      exp_t me;
      me = model(sof, int'(w), d);
      q.push_back(use_tab ? te : me);
      in_valid = 1; in_sof = sof; img_width = w; in_data = d;
      step();
      in_valid = 0; in_sof = 0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      m_row = 0; m_col = 0; m_w = 4096;
      rst_n = 0; in_valid = 0; in_sof = 0; img_width = 13'd4; in_data = 0;

      tab[0]  = mk(1, 8'h00, 0, 0, 0, 24'h000000);
      tab[1]  = mk(0, 8'h01, 1, 0, 0, 24'h000001);
      tab[2]  = mk(0, 8'h02, 2, 0, 0, 24'h000002);
      tab[3]  = mk(0, 8'h03, 3, 1, 0, 24'h000003);
      tab[4]  = mk(0, 8'h10, 0, 0, 1, 24'h000010);
      tab[5]  = mk(0, 8'h11, 1, 0, 1, 24'h000111);
      tab[6]  = mk(0, 8'h12, 2, 0, 1, 24'h000212);
      tab[7]  = mk(0, 8'h13, 3, 1, 1, 24'h000313);
      tab[8]  = mk(0, 8'h20, 0, 0, 2, 24'h001020);
      tab[9]  = mk(0, 8'h21, 1, 0, 2, 24'h011121);
      tab[10] = mk(0, 8'h22, 2, 0, 2, 24'h021222);
      tab[11] = mk(0, 8'h23, 3, 1, 2, 24'h031323);

      @(posedge clk); #1;
      chk_zero("reset");
      rst_n = 1;
      idle(2);

      // back-to-back pixels
      foreach (tab[i]) send(tab[i].sof, tab[i].w, tab[i].d, 1, tab[i].e);

      // blanking between pixels; width changes without sof must be ignored
      foreach (tab[i]) begin
         send(tab[i].sof, tab[i].sof ? tab[i].w : 13'd7, tab[i].d, 1, tab[i].e);
         idle(5);
      end

      // mid-line sof with a narrower width
      send(0, 13'd4, 8'h30, 0, '0);
      send(0, 13'd4, 8'h31, 0, '0);
      send(1, 13'd2, 8'h32, 0, '0);
      send(0, 13'd4, 8'h33, 0, '0);
      send(0, 13'd4, 8'h40, 0, '0);
      send(0, 13'd4, 8'h41, 0, '0);
      send(0, 13'd4, 8'h50, 0, '0);

      // asynchronous reset mid-line
      #2 rst_n = 0;
      #1 chk_zero("async_rst");
      @(posedge clk); #1;
      chk_zero("held_rst");
      rst_n = 1;
      m_row = 0; m_col = 0; m_w = 4096; fr.delete();
      send(0, 13'd2, 8'hab, 0, '0);
      send(0, 13'd2, 8'hcd, 0, '0);
      send(0, 13'd2, 8'hef, 0, '0);

      // full-width frame across three lines
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4096; c++)
            send(r == 0 && c == 0, 13'd4096, 8'($urandom), 0, '0);

      idle(3);
      chk("queue_empty", 64'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sdpb_line_buffer.md
SDPB_LINE_BUFFER -- requirements
Module: sdpb_line_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter LINES, default 2, range 1..8, meaning number of delayed lines held.
REQ-003 SHALL have parameter MAX_WIDTH, default 4096, meaning maximum pixels per line; ADDR_W = clog2(MAX_WIDTH).
REQ-004 SHALL have clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have img_width  input  ADDR_W+1  active pixels per line, legal range 2..MAX_WIDTH, sampled only on in_sof.
REQ-007 SHALL have in_valid  input  1  in_data carries a pixel this cycle.
REQ-008 SHALL have in_sof  input  1  first pixel of a frame, qualified by in_valid.
REQ-009 SHALL have in_data  input  DATA_W  pixel data.
REQ-010 SHALL have out_valid  output  1  out_taps is valid this cycle.
REQ-011 SHALL have out_taps  output  (LINES+1)*DATA_W  tap k = same column, k lines above; tap 0 in the LSBs.
REQ-012 SHALL have out_col  output  ADDR_W  column of the current out_taps.
REQ-013 SHALL have out_eol  output  1  out_taps is the last column of its line.
REQ-014 SHALL have out_lines  output  4  count of valid upper taps, saturating at LINES.

Function
REQ-015 Latency SHALL be exactly 1 cycle: out_valid(t+1) = in_valid(t), with no backpressure.
REQ-016 A column counter SHALL advance on each in_valid pixel and wrap from width_q-1 to 0, where width_q is the latched img_width.
REQ-017 in_valid with in_sof SHALL latch img_width, treat the pixel as column 0, and clear the line count to 0.
REQ-018 The line count SHALL increment on each column wrap and saturate at LINES; out_lines SHALL report the count valid at that pixel.
REQ-019 Each line SHALL use one sdp_ram instance, DATA_W x MAX_WIDTH, with a 1-cycle registered read.
REQ-020 The read SHALL be issued at the column in cycle t; the write SHALL occur at the same column in cycle t+1, giving read-before-write.
REQ-021 RAM 0 SHALL be written with the pixel delayed by one cycle; RAM k (k>0) SHALL be written with the RAM k-1 read data.
REQ-022 Tap 0 SHALL be the pixel delayed by one cycle; tap k SHALL be the RAM k-1 read data.
REQ-023 Tap k SHALL be forced to 0 when k > out_lines.
REQ-024 in_valid=0 cycles, such as blanking, SHALL hold all state: no RAM write and no counter change.
REQ-025 in_sof arriving mid-line SHALL restart at column 0 with line count 0; RAM contents are not cleared and are masked by REQ-023.
REQ-026 img_width changes without in_sof SHALL be ignored.

Reset
REQ-027 While rst_n=0, out_valid, out_eol, out_col, out_lines, out_taps, the column counter, the line count and the pipeline registers SHALL all be 0.
REQ-028 width_q SHALL reset to MAX_WIDTH.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 The first in_valid after reset without in_sof SHALL be treated as column 0, line count 0.

Structure
REQ-031 ADDR_W derivation and the LINES and MAX_WIDTH bounds SHALL live in the shared ISP constants package, together with the tap-index helper.
REQ-032 Sub-module sdp_ram SHALL be a parametrised (width, depth) single-clock simple dual-port RAM with a registered read, inferred rather than vendor-instantiated, and instantiated LINES times via generate.

Verification
REQ-033 Setup: LINES=2, img_width=4, pixel=row*16+col, frame starting with in_sof. At row 2 col 1 -> taps {0x01,0x11,0x21}, out_lines=2, out_col=1.
REQ-034 Same setup, row 0 col 3 -> out_eol=1, taps {0,0,0x03}, out_lines=0. Row 1 col 0 -> taps {0,0x00,0x10}, out_lines=1.
REQ-035 Insert 5 idle cycles between every pixel -> tap values identical to REQ-033, and out_valid only 1 cycle after each in_valid.
REQ-036 in_sof at row 3 col 2 with img_width=2 -> that pixel has out_col=0 and out_lines=0. The next line's col 1 has out_lines=1 and tap1 = the pixel from the previous line's col 1.
REQ-037 Assert rst_n=0 mid-line for 1 cycle -> outputs 0 asynchronously. The next pixel gives out_col=0, out_lines=0, and upper taps 0.
REQ-038 MAX_WIDTH=4096, img_width=4096, 3 lines -> col 4095 has out_eol=1 and the counter wraps to 0; tap k matches a reference model throughout.
